// File: rtl/sha_feedforward_digest_stage_pkg.sv
// ---------------------------------------------------------------------------
// sha_feedforward_digest_stage_pkg: SHA-256 state types, IV and result entry.
// Optional hit flag under SHA_FEEDFORWARD_TARGET_CHECK_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sha_feedforward_digest_stage_pkg;

  // Word k is H<k> / round variable k (a = word 0).
  typedef logic [7:0][31:0] HashState;

  localparam HashState SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef struct packed {
    HashState digest;
`ifdef SHA_FEEDFORWARD_TARGET_CHECK_EN
    logic     hit;
`endif
  } result_t;

`ifdef SHA_FEEDFORWARD_TARGET_CHECK_EN
  // Bitcoin view: H7 is most significant, each word byte-reversed.
  function automatic logic target_hit(input HashState d, input int zero_bits);
    logic [255:0] v;
    v = '0;
    for (int w = 0; w < 8; w++) begin
      v[255-32*w -: 32] = {d[7-w][7:0], d[7-w][15:8], d[7-w][23:16], d[7-w][31:24]};
    end
    if (zero_bits <= 0) return 1'b1;
    return ((v >> (256 - zero_bits)) == '0);
  endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/sha_result_fifo.sv
// ---------------------------------------------------------------------------
// sha_result_fifo: first-word-fall-through result FIFO with sticky overflow.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha_result_fifo
  import sha_feedforward_digest_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  result_t                  push_data,
  input  logic                     pop_ready,
  output result_t                  head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  result_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign head_valid = (count != '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign do_pop     = head_valid && pop_ready;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push    = push_valid && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
      if (push_valid && full && !do_pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/sha_feedforward_digest_stage.sv
// ---------------------------------------------------------------------------
// sha_feedforward_digest_stage: SHA-256 feed-forward add plus result FIFO.
// Optional target check: SHA_FEEDFORWARD_TARGET_CHECK_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha_feedforward_digest_stage
  import sha_feedforward_digest_stage_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ZERO_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  HashState               state_i,
  input  logic                   valid_i,
  input  logic                   newblock_i,
  input  logic                   midstate_we_i,
  input  HashState               midstate_i,
  output HashState               digest_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overflow_o,
  output logic [$clog2(DEPTH):0] count_o
`ifdef SHA_FEEDFORWARD_TARGET_CHECK_EN
  ,
  output logic                   hit_o
`endif
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("DEPTH must be a power of two in 2..16");
  end
  if (ZERO_BITS < 0 || ZERO_BITS > 256) begin : g_zero_bits_check
    $error("ZERO_BITS must be in 0..256");
  end

  HashState midstate;
  HashState chain;
  HashState sum;
  result_t  s1_next;
  result_t  s1_entry;
  logic     s1_valid;
  result_t  head;

  always_comb begin
    chain = newblock_i ? SHA256_IV : midstate;
    sum   = '0;
    // Independent 32-bit adds; carries never cross word boundaries.
    for (int k = 0; k < 8; k++) begin
      sum[k] = state_i[k] + chain[k];
    end
    s1_next        = '0;
    s1_next.digest = sum;
`ifdef SHA_FEEDFORWARD_TARGET_CHECK_EN
    s1_next.hit    = target_hit(sum, ZERO_BITS);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      midstate <= SHA256_IV;
      s1_valid <= 1'b0;
    end else begin
      if (midstate_we_i) midstate <= midstate_i;
      s1_valid <= valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (valid_i) s1_entry <= s1_next;
  end

  sha_result_fifo #(
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (s1_valid),
    .push_data  (s1_entry),
    .pop_ready  (ready_i),
    .head       (head),
    .head_valid (valid_o),
    .count      (count_o),
    .overflow   (overflow_o)
  );

  assign digest_o = head.digest;
`ifdef SHA_FEEDFORWARD_TARGET_CHECK_EN
  assign hit_o    = valid_o && head.hit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sha_feedforward_digest_stage.sv
// ---------------------------------------------------------------------------
// tb_sha_feedforward_digest_stage: scoreboard bench for the feed-forward stage.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sha_feedforward_digest_stage;
  import sha_feedforward_digest_stage_pkg::*;

  localparam int DEPTH     = 4;
  localparam int ZERO_BITS = 32;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  HashState      state_i;
  logic          valid_i;
  logic          newblock_i;
  logic          midstate_we_i;
  HashState      midstate_i;
  HashState      digest_o;
  logic          valid_o;
  logic          ready_i;
  logic          overflow_o;
  logic [CW-1:0] count_o;
`ifdef SHA_FEEDFORWARD_TARGET_CHECK_EN
  logic          hit_o;
`endif

  typedef struct {
    HashState d;
    logic     h;
  } exp_t;

  exp_t     exp_q[$];
  HashState m_mid;
  int       checks = 0;
  int       errors = 0;

  always #5 clk = ~clk;

  sha_feedforward_digest_stage #(
    .DEPTH         (DEPTH),
    .ZERO_BITS     (ZERO_BITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .state_i       (state_i),
    .valid_i       (valid_i),
    .newblock_i    (newblock_i),
    .midstate_we_i (midstate_we_i),
    .midstate_i    (midstate_i),
    .digest_o      (digest_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .overflow_o    (overflow_o),
    .count_o       (count_o)
`ifdef SHA_FEEDFORWARD_TARGET_CHECK_EN
    ,
    .hit_o         (hit_o)
`endif
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leading zeros of the digest read as a little-endian 256-bit number.
  function automatic int lz(input HashState d);
    int         n;
    logic       done;
    logic [7:0] byt;
    n    = 0;
    done = 1'b0;
    for (int j = 31; j >= 0; j--) begin
      byt = d[j/4][(3 - j%4)*8 +: 8];
      for (int b = 7; b >= 0; b--) begin
        if (!done) begin
          if (byt[b]) done = 1'b1;
          else n++;
        end
      end
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input HashState s, input logic nb, input logic v,
                       input logic we, input HashState mv);
    exp_t e;
    if (v) begin
      for (int k = 0; k < 8; k++) e.d[k] = s[k] + (nb ? SHA256_IV[k] : m_mid[k]);
      e.h = (lz(e.d) >= ZERO_BITS);
      exp_q.push_back(e);
    end
    if (we) m_mid = mv;
    state_i       = s;
    newblock_i    = nb;
    valid_i       = v;
    midstate_we_i = we;
    midstate_i    = mv;
    tick();
    valid_i       = 1'b0;
    midstate_we_i = 1'b0;
    state_i       = ~s;
    newblock_i    = ~nb;
  endtask

  function automatic HashState rand_state();
    HashState s;
    for (int k = 0; k < 8; k++) s[k] = $urandom;
    return s;
  endfunction

  task automatic drain();
    tick();
    tick();
    ready_i = 1'b1;
    for (int i = 0; i < 40 && valid_o; i++) tick();
    check("drain_valid_low", 256'(valid_o), 256'(0));
    check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    ready_i = 1'b0;
  endtask

  // Compare the head against the scoreboard whenever it is about to be popped.
  always @(negedge clk) begin
    if (rst && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 256'(1), 256'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("digest", digest_o, e.d);
`ifdef SHA_FEEDFORWARD_TARGET_CHECK_EN
        check("hit", 256'(hit_o), 256'(e.h));
`endif
      end
    end
  end

  initial begin
    HashState s;
    rst           = 1'b0;
    state_i       = '0;
    valid_i       = 1'b0;
    newblock_i    = 1'b0;
    midstate_we_i = 1'b0;
    midstate_i    = '0;
    ready_i       = 1'b0;
    m_mid         = SHA256_IV;

    #12;
    check("rst_valid", 256'(valid_o), 256'(0));
    check("rst_count", 256'(count_o), 256'(0));
    check("rst_overflow", 256'(overflow_o), 256'(0));
`ifdef SHA_FEEDFORWARD_TARGET_CHECK_EN
    check("rst_hit", 256'(hit_o), 256'(0));
`endif
    tick();
    rst = 1'b1;
    tick();

    // Single push of zero state -> IV, two-cycle latency
    drive('0, 1'b1, 1'b1, 1'b0, '0);
    check("latency_1cyc_valid", 256'(valid_o), 256'(0));
    tick();
    check("latency_2cyc_valid", 256'(valid_o), 256'(1));
    check("iv_digest", digest_o, SHA256_IV);
    check("count_one", 256'(count_o), 256'(1));
    ready_i = 1'b1;
    tick();
    check("valid_after_pop", 256'(valid_o), 256'(0));
    ready_i = 1'b0;

    // Word wrap with no cross-word carry
    s    = '0;
    s[0] = 32'hffffffff;
    drive(s, 1'b1, 1'b1, 1'b0, '0);
    tick();
    check("wrap_word0", 256'(digest_o[0]), 256'(32'h6a09e666));
    check("wrap_word1", 256'(digest_o[1]), 256'(32'hbb67ae85));
    drain();

    // Random patterns, mixed chain selection, back-to-back with ready high
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) drive(rand_state(), 1'(i % 2), 1'b1, 1'b0, '0);
    drain();

    // Midstate: write, then use; same-cycle write uses the old value
    drive('0, 1'b0, 1'b0, 1'b1, {8{32'h00000001}});
    drive({8{32'h00000002}}, 1'b0, 1'b1, 1'b0, '0);
    drive({8{32'h00000002}}, 1'b0, 1'b1, 1'b1, {8{32'h00000005}});
    drive({8{32'h00000002}}, 1'b0, 1'b1, 1'b0, '0);
    tick();
    check("mid_old_head", digest_o, {8{32'h00000003}});
    drain();

    // Fill and overflow: the fifth entry is dropped
    for (int i = 0; i < 5; i++) drive(rand_state(), 1'b1, 1'b1, 1'b0, '0);
    tick();
    tick();
    check("full_count", 256'(count_o), 256'(4));
    check("overflow_set", 256'(overflow_o), 256'(1));
    void'(exp_q.pop_back());
    drain();
    check("overflow_sticky", 256'(overflow_o), 256'(1));

    // Asynchronous reset with three buffered entries
    for (int i = 0; i < 3; i++) drive(rand_state(), 1'b1, 1'b1, 1'b0, '0);
    tick();
    tick();
    check("three_buffered", 256'(count_o), 256'(3));
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 256'(valid_o), 256'(0));
    check("async_rst_count", 256'(count_o), 256'(0));
    check("async_rst_overflow", 256'(overflow_o), 256'(0));
    exp_q.delete();
    m_mid = SHA256_IV;
    tick();
    rst = 1'b1;
    tick();

    // Simultaneous push and pop while full
    for (int i = 0; i < 7; i++) begin
      if (i == 5) ready_i = 1'b1;
      drive(rand_state(), 1'b1, 1'b1, 1'b0, '0);
      if (i >= 5) check("full_pushpop_count", 256'(count_o), 256'(4));
    end
    tick();
    check("full_pushpop_count_last", 256'(count_o), 256'(4));
    ready_i = 1'b0;
    tick();
    check("full_pushpop_hold", 256'(count_o), 256'(4));
    check("full_pushpop_no_overflow", 256'(overflow_o), 256'(0));
    drain();

`ifdef SHA_FEEDFORWARD_TARGET_CHECK_EN
    // 32 leading zero bits hits, 31 misses
    s    = '0;
    s[7] = 32'h00000000 - SHA256_IV[7];
    drive(s, 1'b1, 1'b1, 1'b0, '0);
    tick();
    check("hit32", 256'(hit_o), 256'(1));
    drain();
    s[7] = 32'h01000000 - SHA256_IV[7];
    drive(s, 1'b1, 1'b1, 1'b0, '0);
    tick();
    check("hit31", 256'(hit_o), 256'(0));
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sha_feedforward_digest_stage.md
Name: sha_feedforward_digest_stage

Overview:
- Sits directly downstream of the final pipelined round stage; consumes its HashState, valid and newblock outputs.
- Performs the SHA-256 feed-forward add (round state + chaining value) to produce the 256-bit digest.
- Buffers results in a small FIFO with a ready/valid interface toward the result collector.
- The upstream pipeline cannot stall, so overflow is flagged, not back-pressured.

Parameters:
- DEPTH, 4, result FIFO entries; power of two, 2..16.
- ZERO_BITS, 32, required leading-zero count for target hit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- state_i  in  HashState (256)  final round state a..h from the last round stage.
- valid_i  in  1  state_i valid this cycle.
- newblock_i  in  1  1 = first block of message (chain = SHA-256 IV); 0 = continuation (chain = midstate register).
- midstate_we_i  in  1  load midstate register.
- midstate_i  in  HashState (256)  midstate value.
- digest_o  out  HashState (256)  FIFO head digest H0..H7.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts head when valid_o && ready_i.
- overflow_o  out  1  sticky; a result arrived while FIFO full.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - valid_o=0, overflow_o=0, count_o=0.
  - FIFO pointers=0.
  - Midstate register = SHA-256 IV.
  - Stage-1 valid=0.
  - digest_o is don't-care while valid_o=0.
- Stage 1 (registered, 1 cycle):
  - sum[k] = state_i[k] + chain[k] mod 2^32, per word independently; no carry between words.
  - chain = IV when newblock_i=1, else the midstate register.
  - Capture valid_i.
- Midstate write:
  - Takes effect the next cycle.
  - An input presented in the same cycle uses the old midstate.
- Stage 2: FIFO push when stage-1 valid is set.
  - Latency valid_i -> valid_o = 2 cycles when the FIFO was empty.
  - FIFO is first-word-fall-through: digest_o shows the head entry whenever valid_o=1.
- Pop: valid_o && ready_i.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full (count unchanged) and empty-with-pop-impossible (push only).
- Push when full and no pop:
  - Entry is dropped and FIFO contents are unchanged.
  - overflow_o set next cycle; stays high until reset.
- Pointers wrap modulo DEPTH.
- count_o reflects the registered occupancy.
- valid_i=0 cycles: state_i and newblock_i are ignored.
- Reset mid-operation: all in-flight and buffered results are discarded.

Optional Feature:
- Macro: SHA_FEEDFORWARD_TARGET_CHECK_EN.
- With the macro defined:
  - Extra output hit_o (1 bit) travels with each FIFO entry.
  - hit = leading-zero count of the digest, taken H7 first, byte-reversed per word as in Bitcoin convention, is >= ZERO_BITS.
  - Computed in stage 1 from the sum and stored alongside the digest.
  - hit_o is 0 when valid_o=0 and 0 after reset.
- Without the macro: no hit_o port and no comparator logic.

Decomposition:
- Shared package (existing SHA package):
  - HashState typedef.
  - SHA256_IV constant (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19).
  - Result entry typedef (digest plus optional hit).
- Natural sub-module: sha_result_fifo.
  - Parameterised FWFT FIFO with ready/valid, count and overflow.
  - Instantiated once.
- The feed-forward adder stays in the top module.

Test Plan:
- Reset then single push: state_i = all zero, newblock_i=1, valid_i=1 for one cycle -> 2 cycles later valid_o=1, digest_o = IV; ready_i=1 pops; valid_o=0 next cycle.
- Word wrap: state_i word0 = ffffffff, chain IV, newblock_i=1 -> digest word0 = 6a09e666; other words unaffected (no cross-word carry).
- Midstate path: write midstate = all 00000001 with midstate_we_i=1, next cycle push state_i = all 00000002 with newblock_i=0 -> digest all 00000003. Same-cycle write-plus-push -> uses the previous midstate.
- Fill and overflow with DEPTH=4: ready_i=0, push 5 consecutive tagged states -> count_o=4, overflow_o=1, and the first 4 are popped in order with the 5th absent.
- Simultaneous push/pop at full with ready_i=1 -> count_o stays 4, ordering preserved, overflow_o stays 0.
- Async reset asserted mid-stream with 3 entries buffered -> valid_o, count_o and overflow_o go 0 immediately without waiting for clk. With SHA_FEEDFORWARD_TARGET_CHECK_EN defined, a digest with 32 leading zero bits -> hit_o=1, and 31 -> hit_o=0.
